// File: rtl/quad_encoder.sv
// Quadrature encoder decoder: A/B/Z synchroniser, glitch filter, 4x position counter, index latch.
// Optional QUAD_ENCODER_INDEX_RESET_EN: a qualifying index edge also zeroes the position count.
module quad_encoder #(
   parameter int COUNT_WIDTH = 32,
   parameter int FILTER_LEN  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ENC_A,
   input  logic                   ENC_B,
   input  logic                   ENC_Z,
   input  logic                   enable,
   input  logic                   clear,
   output logic [COUNT_WIDTH-1:0] count,
   output logic [COUNT_WIDTH-1:0] index_count,
   output logic                   index_seen,
   output logic                   error
);

   localparam logic [7:0]             RUN_LAST = 8'(FILTER_LEN - 1);
   localparam logic [COUNT_WIDTH-1:0] ONE      = COUNT_WIDTH'(1);

   // Bit order in the 3-bit vectors: [0]=A, [1]=B, [2]=Z
   logic [2:0]             s1;
   logic [2:0]             s2;
   logic [2:0]             filt;
   logic [7:0]             run_cnt [3];
   logic [1:0]             prime_cnt;
   logic                   primed;
   logic                   a_d;
   logic                   b_d;
   logic                   z_d;
   logic [1:0]             pos_diff;
   logic                   z_rise;
   logic                   illegal;
   logic [COUNT_WIDTH-1:0] count_next;

   function automatic logic [1:0] gray_pos(input logic a, input logic b);
      case ({a, b})
         2'b00:   gray_pos = 2'd0;
         2'b01:   gray_pos = 2'd1;
         2'b11:   gray_pos = 2'd2;
         default: gray_pos = 2'd3;
      endcase
   endfunction

   assign primed = (prime_cnt == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {ENC_Z, ENC_B, ENC_A};
         s2 <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prime_cnt <= '0;
      end else if (!primed) begin
         prime_cnt <= prime_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         filt <= '0;
         for (int i = 0; i < 3; i++) run_cnt[i] <= '0;
      end else if (!primed) begin
         filt <= s2;
         for (int i = 0; i < 3; i++) run_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == filt[i]) begin
               run_cnt[i] <= '0;
            end else if (run_cnt[i] == RUN_LAST) begin
               filt[i]    <= s2[i];
               run_cnt[i] <= '0;
            end else begin
               run_cnt[i] <= run_cnt[i] + 8'd1;
            end
         end
      end
   end

   // During priming the history follows s2 together with filt, so the first
   // primed cycle sees no difference and the settled pin state becomes the reference.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_d <= 1'b0;
         b_d <= 1'b0;
         z_d <= 1'b0;
      end else if (!primed) begin
         a_d <= s2[0];
         b_d <= s2[1];
         z_d <= s2[2];
      end else begin
         a_d <= filt[0];
         b_d <= filt[1];
         z_d <= filt[2];
      end
   end

   always_comb begin
      pos_diff   = gray_pos(filt[0], filt[1]) - gray_pos(a_d, b_d);
      illegal    = primed && (pos_diff == 2'd2);
      z_rise     = primed && filt[2] && !z_d;
      count_next = count;
      if (primed && pos_diff == 2'd1) count_next = count + ONE;
      if (primed && pos_diff == 2'd3) count_next = count - ONE;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count       <= '0;
         index_count <= '0;
         index_seen  <= 1'b0;
         error       <= 1'b0;
      end else begin
         if (illegal) error <= 1'b1;
         if (enable) begin
            count <= count_next;
            if (z_rise) begin
               index_count <= count_next;
               index_seen  <= 1'b1;
`ifdef QUAD_ENCODER_INDEX_RESET_EN
               count       <= '0;
`endif
            end
         end
      end
   end

endmodule
